dispense_controller: RTL and testbench

Parametrised successor to the vending machine output handler. It accepts a transaction-end pulse with inserted money, price and item selection. It drives a one-hot item strobe under an acknowledge handshake and then pays out change coin by coin with valid/ready backpressure, instead of presenting change as a single combinational value. It sits between the transaction FSM and the physical dispenser and coin-hopper interfaces.

---
 rtl/vending_pkg.sv | 16 +
 rtl/coin_selector.sv | 14 +
 rtl/dispense_controller.sv | 112 +++++++++++
 tb/tb_dispense_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// vending_pkg: dispense FSM state encoding and coin denominations.
package vending_pkg;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPENSE = 2'd1;
  localparam logic [1:0] ST_PAYOUT   = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;
  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    DISPENSE = ST_DISPENSE,
    PAYOUT   = ST_PAYOUT,
    DONE     = ST_DONE
  } disp_state_t;
  localparam int unsigned COIN_10 = 10;
  localparam int unsigned COIN_5  = 5;
  localparam int unsigned COIN_1  = 1;
endpackage

// File: rtl/coin_selector.sv
// coin_selector: greedy pick of the largest coin in {10,5,1} not above remaining.
module coin_selector
  import vending_pkg::*;
#(
  parameter int MONEY_W = 8
) (
  input  logic [MONEY_W-1:0] i_remaining,
  output logic [MONEY_W-1:0] o_coin
);
  always_comb
    o_coin = i_remaining >= MONEY_W'(COIN_10) ? MONEY_W'(COIN_10) :
             i_remaining >= MONEY_W'(COIN_5)  ? MONEY_W'(COIN_5)  :
             i_remaining >= MONEY_W'(COIN_1)  ? MONEY_W'(COIN_1)  : '0;
endmodule

// File: rtl/dispense_controller.sv
// dispense_controller: one-hot item strobe with ack, then coin-by-coin change payout.
// Optional dispense watchdog enabled by `define DISPENSE_TIMEOUT_EN.
module dispense_controller
  import vending_pkg::*;
#(
  parameter int N_ITEMS      = 4,
  parameter int MONEY_W      = 8,
  parameter int SEL_W        = $clog2(N_ITEMS),
  parameter int DISP_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               end_trans,
  input  logic [MONEY_W-1:0] sum_money,
  input  logic [MONEY_W-1:0] price,
  input  logic [SEL_W-1:0]   item_select,
  output logic [N_ITEMS-1:0] item_onehot,
  input  logic               item_ack,
  output logic               coin_valid,
  output logic [MONEY_W-1:0] coin_value,
  input  logic               coin_ready,
  output logic [MONEY_W-1:0] change,
  output logic               refund,
  output logic               busy,
  output logic               done,
  output logic               fault
);
  disp_state_t        r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [MONEY_W-1:0] r_rem;
  logic [MONEY_W-1:0] r_change;
  logic               r_refund;
  logic               w_ok;
  logic [MONEY_W-1:0] w_start;
  logic [MONEY_W-1:0] w_coin;
  logic [MONEY_W-1:0] w_rem_next;

  coin_selector #(.MONEY_W(MONEY_W)) u_coin_selector (
    .i_remaining (r_rem),
    .o_coin      (w_coin)
  );

  assign w_ok        = sum_money >= price && 32'(item_select) < N_ITEMS;
  assign w_start     = w_ok ? sum_money - price : sum_money;
  assign w_rem_next  = r_rem - w_coin;
  assign item_onehot = r_state == DISPENSE ? N_ITEMS'(1) << r_sel : '0;
  assign coin_valid  = r_state == PAYOUT;
  assign coin_value  = coin_valid ? w_coin : '0;
  assign change      = r_change;
  assign refund      = r_refund;
  assign busy        = r_state != IDLE;
  assign done        = r_state == DONE;

`ifdef DISPENSE_TIMEOUT_EN
  localparam int CNT_W = $clog2(DISP_TIMEOUT + 1);
  logic [CNT_W-1:0]   r_cnt;
  logic [MONEY_W-1:0] r_sum;
  logic               r_fault;
  logic               w_tmo;
  assign w_tmo = r_state == DISPENSE && !item_ack && r_cnt == CNT_W'(DISP_TIMEOUT - 1);
  assign fault = r_fault;
  // r_sum keeps the inserted money so a timed-out dispense can refund it in full
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= '0;
      r_sum   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_tmo;
      r_cnt   <= r_state == DISPENSE ? r_cnt + 1'b1 : '0;
      if (r_state == IDLE && end_trans) r_sum <= sum_money;
    end
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_rem    <= '0;
      r_change <= '0;
      r_refund <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (end_trans) begin
            r_sel    <= item_select;
            r_refund <= !w_ok;
            r_rem    <= w_start;
            r_change <= w_start;
            r_state  <= w_ok ? DISPENSE : sum_money == '0 ? DONE : PAYOUT;
          end
        DISPENSE:
          if (item_ack) r_state <= r_rem != '0 ? PAYOUT : DONE;
`ifdef DISPENSE_TIMEOUT_EN
          else if (w_tmo) begin
            r_refund <= 1'b1;
            r_rem    <= r_sum;
            r_change <= r_sum;
            r_state  <= r_sum != '0 ? PAYOUT : DONE;
          end
`endif
        PAYOUT:
          if (coin_ready) begin
            r_rem <= w_rem_next;
            if (w_rem_next == '0) r_state <= DONE;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dispense_controller.sv
// tb_dispense_controller: directed vectors with hand-computed expectations.
module tb_dispense_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       end_trans = 1'b0;
  logic [7:0] sum_money = '0;
  logic [7:0] price = '0;
  logic [1:0] item_select = '0;
  logic [3:0] item_onehot;
  logic       item_ack = 1'b0;
  logic       coin_valid;
  logic [7:0] coin_value;
  logic       coin_ready = 1'b0;
  logic [7:0] change;
  logic       refund;
  logic       busy;
  logic       done;
  logic       fault;
  int n_cmp = 0;
  int n_bad = 0;

  dispense_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .end_trans   (end_trans),
    .sum_money   (sum_money),
    .price       (price),
    .item_select (item_select),
    .item_onehot (item_onehot),
    .item_ack    (item_ack),
    .coin_valid  (coin_valid),
    .coin_value  (coin_value),
    .coin_ready  (coin_ready),
    .change      (change),
    .refund      (refund),
    .busy        (busy),
    .done        (done),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] s, input logic [7:0] p, input logic [1:0] sel);
    sum_money = s;
    price = p;
    item_select = sel;
    end_trans = 1'b1;
    tick();
    end_trans = 1'b0;
  endtask

  task automatic take_coin(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, coin_valid, 1);
    check({tag, "_value"}, coin_value, exp);
    tick();
  endtask

  task automatic ack();
    item_ack = 1'b1;
    tick();
    item_ack = 1'b0;
  endtask

  task automatic finish_txn(input string tag);
    check({tag, "_done"}, done, 1);
    check({tag, "_done_busy"}, busy, 1);
    check({tag, "_done_cv"}, coin_valid, 0);
    tick();
    check({tag, "_done_gone"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_onehot"}, item_onehot, 0);
    check({tag, "_cv"}, coin_valid, 0);
    check({tag, "_cval"}, coin_value, 0);
    check({tag, "_change"}, change, 0);
    check({tag, "_refund"}, refund, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fault"}, fault, 0);
  endtask

  initial begin
    #2;
    check_reset("rst");
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // purchase with change: 58 - 35 = 23 -> 10,10,1,1,1
    coin_ready = 1'b1;
    start(58, 35, 2);
    check("pc_busy", busy, 1);
    check("pc_onehot", item_onehot, 4'b0100);
    check("pc_change", change, 23);
    check("pc_refund", refund, 0);
    check("pc_cv", coin_valid, 0);
    start(5, 1, 1);
    check("pc_ignored_change", change, 23);
    check("pc_ignored_onehot", item_onehot, 4'b0100);
    tick();
    check("pc_hold_onehot", item_onehot, 4'b0100);
    check("pc_nofault", fault, 0);
    ack();
    check("pc_ack_onehot", item_onehot, 0);
    take_coin("pc_c1", 10);
    take_coin("pc_c2", 10);
    take_coin("pc_c3", 1);
    take_coin("pc_c4", 1);
    take_coin("pc_c5", 1);
    finish_txn("pc");
    check("pc_change_held", change, 23);

    // exact money
    start(100, 100, 0);
    check("ex_onehot", item_onehot, 4'b0001);
    check("ex_change", change, 0);
    check("ex_cv", coin_valid, 0);
    ack();
    check("ex_onehot_off", item_onehot, 0);
    finish_txn("ex");

    // insufficient money: full refund, no dispense
    start(20, 30, 1);
    check("in_onehot", item_onehot, 0);
    check("in_refund", refund, 1);
    check("in_change", change, 20);
    take_coin("in_c1", 10);
    check("in_onehot2", item_onehot, 0);
    take_coin("in_c2", 10);
    finish_txn("in");

    // backpressure: change 7, hopper stalls 3 cycles
    coin_ready = 1'b0;
    start(17, 10, 3);
    check("bp_onehot", item_onehot, 4'b1000);
    check("bp_refund", refund, 0);
    ack();
    for (int i = 0; i < 3; i++) begin
      check("bp_stall_valid", coin_valid, 1);
      check("bp_stall_value", coin_value, 5);
      tick();
    end
    coin_ready = 1'b1;
    take_coin("bp_c1", 5);
    take_coin("bp_c2", 1);
    take_coin("bp_c3", 1);
    finish_txn("bp");

    // reset mid-payout after the 2nd coin of 23
    start(58, 35, 2);
    ack();
    take_coin("rs_c1", 10);
    take_coin("rs_c2", 10);
    check("rs_pre_value", coin_value, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset("rs");
    tick();
    rst_n = 1'b1;
    tick();
    check_reset("rs_after");
    // zero money with an unaffordable price goes straight to DONE
    start(0, 5, 1);
    check("z_refund", refund, 1);
    check("z_change", change, 0);
    check("z_onehot", item_onehot, 0);
    finish_txn("z");
    start(12, 2, 1);
    check("post_onehot", item_onehot, 4'b0010);
    check("post_change", change, 10);
    check("post_refund", refund, 0);
    ack();
    take_coin("post_c1", 10);
    finish_txn("post");

`ifdef DISPENSE_TIMEOUT_EN
    start(50, 40, 1);
    for (int i = 0; i < 15; i++) begin
      check("to_onehot", item_onehot, 4'b0010);
      check("to_nofault", fault, 0);
      tick();
    end
    check("to_fault", fault, 1);
    check("to_refund", refund, 1);
    check("to_change", change, 50);
    check("to_onehot_off", item_onehot, 0);
    for (int i = 0; i < 5; i++) begin
      take_coin("to_c", 10);
      check("to_fault_gone", fault, 0);
    end
    finish_txn("to");
`else
    start(50, 40, 1);
    for (int i = 0; i < 20; i++) tick();
    check("nt_onehot", item_onehot, 4'b0010);
    check("nt_fault", fault, 0);
    check("nt_cv", coin_valid, 0);
    ack();
    take_coin("nt_c1", 10);
    finish_txn("nt");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
